// File: rtl/nes_dma_engine.sv
// nes_dma_engine -- CPU-bus DMA for OAM sprite copy (ch0) and DMC sample fetch (ch1).
//
// The engine halts the CPU through cpu_rdy and takes the bus (bus_own=1). Reads are
// only issued on get cycles (phase=0), and writes only on put cycles (phase=1).
// A DMC fetch takes priority over OAM at any get cycle.
//
// Ports:
//   clk, reset        one edge per CPU cycle; asynchronous active-high reset
//   cpu_addr/we/wdata CPU write snoop; a write to TRIGGER_ADDR starts an OAM copy of page cpu_wdata
//   bus_rdata         read data from the decoded bus
//   dmc_req/dmc_addr  level request for one DMC byte, held until dmc_ack
//   cpu_rdy           0 = CPU halted
//   bus_own           1 = dma_addr/dma_we/dma_wdata drive the bus
//   dma_addr/we/wdata DMA bus cycle
//   dmc_ack/dmc_data  one-cycle pulse with the fetched DMC byte
//   oam_busy          OAM transfer pending or in progress
//   oam_index         next OAM byte index
module nes_dma_engine #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256,
  parameter bit          DMC_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        cpu_rdy,
  output logic        bus_own,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
  output logic        oam_busy,
  output logic [7:0]  oam_index
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT, DONE} state_t;

  state_t     state, state_nx;
  logic       phase;      // 0 = get cycle, 1 = put cycle
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] hold;
  logic       oam_pend;
  logic       trig_q;
  logic       trig_dec;
  logic       trig;
  logic       dmc_go;
  logic       dmc_fetch;
  logic       oam_rd;
  logic       oam_wr;

  // Edge-detect the trigger decode so a held write strobe starts one transfer.
  // A trigger while a transfer is pending is dropped, leaving page untouched.
  assign trig_dec = cpu_we && (cpu_addr == TRIGGER_ADDR);
  assign trig     = trig_dec && !trig_q && !oam_pend;
  assign dmc_go   = DMC_EN && dmc_req;

  assign oam_busy  = oam_pend;
  assign oam_index = index;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cpu_rdy   = 1'b1;
    bus_own   = 1'b0;
    dma_addr  = 16'h0000;
    dma_we    = 1'b0;
    dma_wdata = 8'h00;
    dmc_fetch = 1'b0;
    oam_rd    = 1'b0;
    oam_wr    = 1'b0;
    case (state)
      IDLE: if (oam_pend || dmc_go) state_nx = HALT;
      HALT: begin
        cpu_rdy  = 1'b0;
        // GET must land on a get cycle; burn one put cycle if HALT sits on a get.
        state_nx = phase ? GET : ALIGN;
      end
      ALIGN: begin
        cpu_rdy  = 1'b0;
        state_nx = GET;
      end
      GET: begin
        cpu_rdy = 1'b0;
        if (dmc_go) begin
          bus_own   = 1'b1;
          dma_addr  = dmc_addr;
          dmc_fetch = 1'b1;
          // The DMC read consumed the get slot; the following put slot is idle.
          state_nx  = oam_pend ? ALIGN : DONE;
        end else if (oam_pend) begin
          bus_own  = 1'b1;
          dma_addr = {page, index};
          oam_rd   = 1'b1;
          state_nx = PUT;
        end else begin
          // DMC request withdrawn before service: nothing to do.
          state_nx = DONE;
        end
      end
      PUT: begin
        cpu_rdy   = 1'b0;
        bus_own   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = OAM_PORT_ADDR;
        dma_wdata = hold;
        oam_wr    = 1'b1;
        state_nx  = (index == LAST_IDX) ? DONE : GET;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= 1'b0;
      trig_q   <= 1'b0;
      page     <= 8'h00;
      index    <= 8'h00;
      hold     <= 8'h00;
      oam_pend <= 1'b0;
      dmc_ack  <= 1'b0;
      dmc_data <= 8'h00;
    end else begin
      phase   <= ~phase;
      trig_q  <= trig_dec;
      dmc_ack <= dmc_fetch;
      if (dmc_fetch) dmc_data <= bus_rdata;
      if (oam_rd)    hold     <= bus_rdata;
      // trig requires !oam_pend and oam_wr implies oam_pend, so these never collide.
      if (trig) begin
        page     <= cpu_wdata;
        index    <= 8'h00;
        oam_pend <= 1'b1;
      end
      if (oam_wr) begin
        if (index == LAST_IDX) begin
          index    <= 8'h00;
          oam_pend <= 1'b0;
        end else begin
          index <= index + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_dma_engine.sv
// Scoreboard bench for nes_dma_engine: stimulus pushes expected bus reads, $2004
// writes and DMC bytes into queues; a negedge monitor pops and compares them.
module tb_nes_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_we, cpu_we4;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata, bus_rdata4;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        cpu_rdy, bus_own, dma_we, dmc_ack, oam_busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dmc_data, oam_index;
  logic        cpu_rdy4, bus_own4, dma_we4, dmc_ack4, oam_busy4;
  logic [15:0] dma_addr4;
  logic [7:0]  dma_wdata4, dmc_data4, oam_index4;

  always #5 clk = ~clk;

  nes_dma_engine dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .bus_rdata(bus_rdata), .dmc_req(dmc_req), .dmc_addr(dmc_addr), .cpu_rdy(cpu_rdy),
    .bus_own(bus_own), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dmc_ack(dmc_ack), .dmc_data(dmc_data), .oam_busy(oam_busy), .oam_index(oam_index));

  nes_dma_engine #(.XFER_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we4), .cpu_wdata(cpu_wdata),
    .bus_rdata(bus_rdata4), .dmc_req(1'b0), .dmc_addr(16'h0000), .cpu_rdy(cpu_rdy4),
    .bus_own(bus_own4), .dma_addr(dma_addr4), .dma_we(dma_we4), .dma_wdata(dma_wdata4),
    .dmc_ack(dmc_ack4), .dmc_data(dmc_data4), .oam_busy(oam_busy4), .oam_index(oam_index4));

  // Memory: page $02 holds i^A5, $C000 holds the DMC byte, other pages a page-dependent pattern.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a == 16'hC000)      return 8'h3C;
    if (a[15:8] == 8'h02)   return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign bus_rdata  = bus_own  ? mem_rd(dma_addr)  : 8'h00;
  assign bus_rdata4 = bus_own4 ? mem_rd(dma_addr4) : 8'h00;

  logic [15:0] exp_rd[$], exp_rd4[$];
  logic [7:0]  exp_wd[$], exp_wd4[$], exp_dmc[$];
  int errors = 0, checks = 0;
  int puts = 0, puts4 = 0, acks = 0, low_cnt = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, want nothing", name, act);
  endtask

  // Edges since reset: the current cycle's phase is cyc%2.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && !cpu_rdy) low_cnt++;
    if (bus_own && !dma_we) begin
      if (exp_rd.size() == 0) bad("unexpected read", dma_addr);
      else chk("read addr", dma_addr, exp_rd.pop_front());
    end
    if (bus_own && dma_we) begin
      puts++;
      if (exp_wd.size() == 0) bad("unexpected put", dma_wdata);
      else begin
        chk("put addr", dma_addr, 16'h2004);
        chk("put data", dma_wdata, exp_wd.pop_front());
      end
    end
    if (dmc_ack) begin
      acks++;
      if (exp_dmc.size() == 0) bad("unexpected dmc_ack", dmc_data);
      else chk("dmc data", dmc_data, exp_dmc.pop_front());
    end
    if (bus_own4 && !dma_we4) begin
      if (exp_rd4.size() == 0) bad("len4 unexpected read", dma_addr4);
      else chk("len4 read addr", dma_addr4, exp_rd4.pop_front());
    end
    if (bus_own4 && dma_we4) begin
      puts4++;
      if (exp_wd4.size() == 0) bad("len4 unexpected put", dma_wdata4);
      else begin
        chk("len4 put addr", dma_addr4, 16'h2004);
        chk("len4 put data", dma_wdata4, exp_wd4.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic align_to(input int p);
    while ((cyc % 2) != p) tick();
  endtask

  // Expected OAM stream; a DMC read is slotted in before OAM read dmc_at (-1 = none).
  task automatic push_oam(input logic [7:0] pg, input int dmc_at);
    for (int i = 0; i < 256; i++) begin
      if (i == dmc_at) exp_rd.push_back(16'hC000);
      exp_rd.push_back({pg, i[7:0]});
      exp_wd.push_back(mem_rd({pg, i[7:0]}));
    end
  endtask

  task automatic trigger(input logic [7:0] pg, input int hold_cycles);
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    cpu_we    = 1'b1;
    repeat (hold_cycles) tick();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (oam_busy && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) bad({name, " completion timeout"}, n);
    repeat (3) tick();
  endtask

  task automatic wait_ack_drop(input string name);
    int n = 0;
    while (!dmc_ack && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) bad({name, " ack timeout"}, n);
    dmc_req = 1'b0;
  endtask

  task automatic wait_put(input logic [7:0] idx);
    int n = 0;
    while (!(bus_own && dma_we && oam_index == idx) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) bad("put wait timeout", idx);
  endtask

  task automatic check_clean(input string name);
    chk({name, " rd queue"}, exp_rd.size(), 0);
    chk({name, " wd queue"}, exp_wd.size(), 0);
    chk({name, " dmc queue"}, exp_dmc.size(), 0);
    chk({name, " oam_index"}, oam_index, 8'h00);
    chk({name, " cpu_rdy"}, cpu_rdy, 1'b1);
  endtask

  initial begin
    int t0, p0, a0;
    reset = 1'b1; cpu_addr = 16'h0; cpu_we = 1'b0; cpu_we4 = 1'b0; cpu_wdata = 8'h0;
    dmc_req = 1'b0; dmc_addr = 16'hC000;
    #23;
    chk("reset cpu_rdy", cpu_rdy, 1'b1);
    chk("reset bus_own", bus_own, 1'b0);
    chk("reset dma_addr", dma_addr, 16'h0);
    chk("reset dma_we", dma_we, 1'b0);
    chk("reset dma_wdata", dma_wdata, 8'h0);
    chk("reset dmc_ack", dmc_ack, 1'b0);
    chk("reset dmc_data", dmc_data, 8'h0);
    chk("reset oam_busy", oam_busy, 1'b0);
    chk("reset oam_index", oam_index, 8'h0);
    reset = 1'b0;
    repeat (3) tick();

    // OAM copy, trigger on a put cycle: HALT lands on put, 1+512 halted cycles.
    align_to(1);
    push_oam(8'h02, -1);
    t0 = low_cnt; p0 = puts;
    trigger(8'h02, 1);
    wait_done("oam1");
    chk("oam1 halt cycles", low_cnt - t0, 513);
    chk("oam1 puts", puts - p0, 256);
    check_clean("oam1");

    // Strobe held 4 cycles from a get cycle, plus a retrigger to page $07 mid-transfer.
    align_to(0);
    push_oam(8'h02, -1);
    t0 = low_cnt; p0 = puts;
    trigger(8'h02, 4);
    repeat (40) tick();
    trigger(8'h07, 1);
    wait_done("oam2");
    chk("oam2 halt cycles", low_cnt - t0, 514);
    chk("oam2 puts", puts - p0, 256);
    check_clean("oam2");

    // Standalone DMC fetch: request on get cycle -> HALT on put -> 2 cycles.
    align_to(0);
    exp_rd.push_back(16'hC000); exp_dmc.push_back(8'h3C);
    t0 = low_cnt; a0 = acks;
    dmc_req = 1'b1;
    wait_ack_drop("dmc1");
    repeat (4) tick();
    chk("dmc1 halt cycles", low_cnt - t0, 2);
    chk("dmc1 acks", acks - a0, 1);
    check_clean("dmc1");

    // Standalone DMC fetch needing ALIGN -> 3 cycles.
    align_to(1);
    exp_rd.push_back(16'hC000); exp_dmc.push_back(8'h3C);
    t0 = low_cnt; a0 = acks;
    dmc_req = 1'b1;
    wait_ack_drop("dmc2");
    repeat (4) tick();
    chk("dmc2 halt cycles", low_cnt - t0, 3);
    chk("dmc2 acks", acks - a0, 1);
    check_clean("dmc2");

    // DMC request withdrawn before service: no fetch, no ack.
    align_to(0);
    a0 = acks;
    dmc_req = 1'b1;
    tick();
    dmc_req = 1'b0;
    repeat (8) tick();
    chk("dmc drop acks", acks - a0, 0);
    check_clean("dmc drop");

    // DMC raised after OAM byte 10 put: served next get, costs 2 extra cycles.
    align_to(1);
    push_oam(8'h02, 11);
    exp_dmc.push_back(8'h3C);
    t0 = low_cnt; p0 = puts;
    trigger(8'h02, 1);
    wait_put(8'd10);
    dmc_req = 1'b1;
    wait_ack_drop("dmc mid");
    wait_done("dmc mid");
    chk("dmc mid halt cycles", low_cnt - t0, 515);
    chk("dmc mid puts", puts - p0, 256);
    check_clean("dmc mid");

    // DMC and trigger in the same cycle: shared HALT, DMC first.
    align_to(0);
    exp_rd.push_back(16'hC000); exp_dmc.push_back(8'h3C);
    push_oam(8'h02, -1);
    t0 = low_cnt;
    dmc_req = 1'b1;
    trigger(8'h02, 1);
    wait_ack_drop("same cycle");
    wait_done("same cycle");
    chk("same cycle halt cycles", low_cnt - t0, 515);
    check_clean("same cycle");

    // Reset at OAM byte 100: immediate return to idle, transfer abandoned.
    align_to(1);
    push_oam(8'h02, -1);
    trigger(8'h02, 1);
    wait_put(8'd100);
    reset = 1'b1;
    #1;
    chk("mid reset cpu_rdy", cpu_rdy, 1'b1);
    chk("mid reset bus_own", bus_own, 1'b0);
    chk("mid reset oam_busy", oam_busy, 1'b0);
    chk("mid reset oam_index", oam_index, 8'h00);
    exp_rd.delete(); exp_wd.delete();
    repeat (3) tick();
    reset = 1'b0;
    p0 = puts;
    repeat (30) tick();
    chk("post reset puts", puts - p0, 0);

    // XFER_LEN=4 build, page $03: four puts then idle.
    for (int i = 0; i < 4; i++) begin
      exp_rd4.push_back({8'h03, i[7:0]});
      exp_wd4.push_back(mem_rd({8'h03, i[7:0]}));
    end
    cpu_addr = 16'h4014; cpu_wdata = 8'h03; cpu_we4 = 1'b1;
    tick();
    cpu_we4 = 1'b0; cpu_addr = 16'h0;
    repeat (20) tick();
    chk("len4 puts", puts4, 4);
    chk("len4 rd queue", exp_rd4.size(), 0);
    chk("len4 wd queue", exp_wd4.size(), 0);
    chk("len4 oam_busy", oam_busy4, 1'b0);
    chk("len4 oam_index", oam_index4, 8'h00);
    chk("len4 cpu_rdy", cpu_rdy4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got %0d checks, want completion", checks);
    $fatal(1, "timeout");
  end

endmodule
